// File: rtl/usb_tx_ll_gen.sv
// USB low-level transmitter: NRZI line encoding with bit stuffing, lead-in J and
// configurable EOP, driven one data bit per bit period by the packet layer.
module usb_tx_ll_gen #(
  parameter int CLK_DIV      = 4,
  parameter int STUFF_LEN    = 6,
  parameter int LEAD_BITS    = 1,
  parameter int EOP_SE0_BITS = 2,
  parameter int EOP_J_BITS   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ls_mode,
  input  logic ll_start,
  input  logic ll_bit,
  input  logic ll_last,
  output logic ll_ack,
  output logic busy,
  output logic phy_tx_dp,
  output logic phy_tx_dn,
  output logic phy_tx_en
);

  localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW   = $clog2(STUFF_LEN + 1);
  localparam int PMAX = (LEAD_BITS > EOP_SE0_BITS)
                        ? ((LEAD_BITS > EOP_J_BITS) ? LEAD_BITS : EOP_J_BITS)
                        : ((EOP_SE0_BITS > EOP_J_BITS) ? EOP_SE0_BITS : EOP_J_BITS);
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(STUFF_LEN);
  localparam logic [PW-1:0] LEAD_LAST = PW'(LEAD_BITS - 1);
  localparam logic [PW-1:0] SE0_LAST  = PW'(EOP_SE0_BITS - 1);
  localparam logic [PW-1:0] EJ_LAST   = PW'(EOP_J_BITS - 1);

  typedef enum logic [2:0] {IDLE, LEAD, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [RW-1:0] run, run_nxt;
  logic          level, level_nxt;
  logic          ls, ls_nxt;
  logic          cur_last, last_nxt;
  logic          ack_nxt, take, br_now;
  logic          en_nxt, dp_nxt, dn_nxt;

  assign br_now = (cnt == CNT_LAST);

  // level is the logical line state: 1 = J, 0 = K, independent of FS/LS polarity
  always_comb begin
    state_nxt = state;
    cnt_nxt   = br_now ? '0 : cnt + CW'(1);
    pcnt_nxt  = pcnt;
    run_nxt   = run;
    level_nxt = level;
    ls_nxt    = ls;
    last_nxt  = cur_last;
    ack_nxt   = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (ll_start) begin
          state_nxt = LEAD;
          ls_nxt    = ls_mode;
          level_nxt = 1'b1;
          run_nxt   = '0;
          pcnt_nxt  = '0;
        end
      end
      LEAD: begin
        if (br_now) begin
          if (pcnt == LEAD_LAST) take = 1'b1;
          else pcnt_nxt = pcnt + PW'(1);
        end
      end
      DATA: begin
        if (br_now) begin
          if (run == RUN_MAX) begin
            state_nxt = STUFF;
            level_nxt = ~level;
            run_nxt   = '0;
          end else if (cur_last) begin
            state_nxt = EOP_SE0;
            pcnt_nxt  = '0;
          end else begin
            take = 1'b1;
          end
        end
      end
      STUFF: begin
        if (br_now) begin
          if (cur_last) begin
            state_nxt = EOP_SE0;
            pcnt_nxt  = '0;
          end else begin
            take = 1'b1;
          end
        end
      end
      EOP_SE0: begin
        if (br_now) begin
          if (pcnt == SE0_LAST) begin
            state_nxt = EOP_J;
            pcnt_nxt  = '0;
            level_nxt = 1'b1;
          end else begin
            pcnt_nxt = pcnt + PW'(1);
          end
        end
      end
      EOP_J: begin
        if (br_now) begin
          if (pcnt == EJ_LAST) begin
            state_nxt = IDLE;
            level_nxt = 1'b1;
          end else begin
            pcnt_nxt = pcnt + PW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Sampling a data bit: NRZI (0 toggles, 1 holds) and the 1s run for stuffing
    if (take) begin
      state_nxt = DATA;
      level_nxt = ll_bit ? level : ~level;
      run_nxt   = ll_bit ? run + RW'(1) : '0;
      last_nxt  = ll_last;
      ack_nxt   = 1'b1;
    end
  end

  always_comb begin
    en_nxt = (state_nxt != IDLE);
    if (state_nxt == EOP_SE0) begin
      dp_nxt = 1'b0;
      dn_nxt = 1'b0;
    end else begin
      dp_nxt = level_nxt ^ ls_nxt;
      dn_nxt = ~(level_nxt ^ ls_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pcnt      <= '0;
      run       <= '0;
      level     <= 1'b1;
      ls        <= 1'b0;
      cur_last  <= 1'b0;
      ll_ack    <= 1'b0;
      busy      <= 1'b0;
      phy_tx_en <= 1'b0;
      phy_tx_dp <= 1'b1;
      phy_tx_dn <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pcnt      <= pcnt_nxt;
      run       <= run_nxt;
      level     <= level_nxt;
      ls        <= ls_nxt;
      cur_last  <= last_nxt;
      ll_ack    <= ack_nxt;
      busy      <= en_nxt;
      phy_tx_en <= en_nxt;
      phy_tx_dp <= dp_nxt;
      phy_tx_dn <= dn_nxt;
    end
  end

endmodule

// File: tb/tb_usb_tx_ll_gen.sv
// Scoreboard bench for usb_tx_ll_gen: two instances (default and CLK_DIV=2/STUFF_LEN=3)
// driven with directed and random packets, checked cycle by cycle against a period-level model.
module tb_usb_tx_ll_gen;

  localparam int CDIV  [2] = '{4, 2};
  localparam int SLEN  [2] = '{6, 3};
  localparam int LEADB [2] = '{1, 2};
  localparam int SE0B  [2] = '{2, 2};
  localparam int EJB   [2] = '{1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ls_mode = '0, ll_start = '0, ll_bit = '0, ll_last = '0;
  wire  [1:0] ll_ack, busy, dp, dn, en;

  int   errors = 0;
  int   checks = 0;
  bit   mon_off = 1'b1;
  bit   pkt [$];
  logic [3:0] exp_q [2][$];

  always #5 clk = ~clk;

  usb_tx_ll_gen #(.CLK_DIV(4), .STUFF_LEN(6), .LEAD_BITS(1), .EOP_SE0_BITS(2), .EOP_J_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .ls_mode(ls_mode[0]), .ll_start(ll_start[0]), .ll_bit(ll_bit[0]),
    .ll_last(ll_last[0]), .ll_ack(ll_ack[0]), .busy(busy[0]),
    .phy_tx_dp(dp[0]), .phy_tx_dn(dn[0]), .phy_tx_en(en[0]));

  usb_tx_ll_gen #(.CLK_DIV(2), .STUFF_LEN(3), .LEAD_BITS(2), .EOP_SE0_BITS(2), .EOP_J_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .ls_mode(ls_mode[1]), .ll_start(ll_start[1]), .ll_bit(ll_bit[1]),
    .ll_last(ll_last[1]), .ll_ack(ll_ack[1]), .busy(busy[1]),
    .phy_tx_dp(dp[1]), .phy_tx_dn(dn[1]), .phy_tx_en(en[1]));

  task automatic checkOutput(input string name, input int s, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, s, $time, act, exp);
    end
  endtask

  // Expected line per bit period from the protocol rules, expanded to one entry per clock:
  // entry = {busy, ack, dp, dn}
  task automatic buildExpected(input int s, input bit ls);
    logic [2:0] per [$];
    logic [1:0] jsym, ksym;
    bit lvl;
    int run;
    jsym = ls ? 2'b01 : 2'b10;
    ksym = ~jsym;
    lvl = 1'b1;
    run = 0;
    repeat (LEADB[s]) per.push_back({1'b0, jsym});
    foreach (pkt[i]) begin
      if (pkt[i]) run++;
      else begin
        lvl = !lvl;
        run = 0;
      end
      per.push_back({1'b1, lvl ? jsym : ksym});
      if (run == SLEN[s]) begin
        lvl = !lvl;
        run = 0;
        per.push_back({1'b0, lvl ? jsym : ksym});
      end
    end
    repeat (SE0B[s]) per.push_back(3'b000);
    repeat (EJB[s]) per.push_back({1'b0, jsym});
    foreach (per[p])
      for (int c = 0; c < CDIV[s]; c++)
        exp_q[s].push_back({1'b1, per[p][2] && (c == 0), per[p][1:0]});
  endtask

  task automatic setSync();
    pkt.delete();
    repeat (7) pkt.push_back(1'b0);
    pkt.push_back(1'b1);
  endtask

  // Drives one packet with the upstream handshake; optional ls_mode noise and start pulses
  task automatic applyStimulus(input int s, input bit ls, input bit tog, input bit noise);
    int n, idx, acks, cycles, limit, wait_cnt;
    bit pending;
    n = pkt.size();
    buildExpected(s, ls);
    idx = 0; acks = 0; cycles = 0; pending = 0; wait_cnt = 0;
    limit = (2 * n + LEADB[s] + SE0B[s] + EJB[s] + 2) * CDIV[s] + 20;
    ls_mode[s] = ls;
    ll_bit[s] = pkt[0];
    ll_last[s] = (n == 1);
    ll_start[s] = 1'b1;
    @(posedge clk); #1;
    ll_start[s] = 1'b0;
    checkOutput("start_en_busy", s, {en[s], busy[s]}, 2'b11);
    while (busy[s] && cycles < limit) begin
      if (ll_ack[s]) begin
        acks++;
        pending = 1'b1;
        wait_cnt = $urandom_range(0, CDIV[s] - 2);
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          idx++;
          pending = 1'b0;
          if (idx < n) begin
            ll_bit[s] = pkt[idx];
            ll_last[s] = (idx == n - 1);
          end
        end else begin
          wait_cnt--;
        end
      end
      ll_start[s] = noise && ($urandom_range(0, 3) == 0);
      if (tog) ls_mode[s] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cycles++;
    end
    ll_start[s] = 1'b0;
    checkOutput("done_in_time", s, (cycles < limit), 1);
    checkOutput("ack_count", s, acks, n);
    checkOutput("expected_left", s, exp_q[s].size(), 0);
    exp_q[s].delete();
    checkOutput("idle_line", s, {en[s], busy[s], dp[s], dn[s]}, {2'b00, ls ? 2'b01 : 2'b10});
    ll_bit[s] = 1'b0;
    ll_last[s] = 1'b0;
    ls_mode[s] = ls;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every enabled cycle consumes one expected entry
  always @(negedge clk) begin
    if (!mon_off) begin
      for (int s = 0; s < 2; s++) begin
        if (en[s]) begin
          if (exp_q[s].size() == 0) checkOutput("unexpected_en", s, 1, 0);
          else checkOutput("line_cycle", s, {busy[s], ll_ack[s], dp[s], dn[s]}, exp_q[s].pop_front());
        end else begin
          checkOutput("idle_busy_ack", s, {busy[s], ll_ack[s]}, 2'b00);
        end
      end
    end
  end

  initial begin
    int s, len;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      checkOutput("reset_state", i, {en[i], busy[i], ll_ack[i], dp[i], dn[i]}, 5'b00010);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_off = 1'b0;

    setSync();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    setSync();
    repeat (8) pkt.push_back(1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    setSync();
    repeat (5) pkt.push_back(1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    setSync();
    pkt.push_back(1'b0); pkt.push_back(1'b1); pkt.push_back(1'b1); pkt.push_back(1'b0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    setSync();
    repeat (9) pkt.push_back(1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    setSync();
    repeat (8) pkt.push_back(1'b1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    pkt.delete();
    pkt.push_back(1'b0); repeat (3) pkt.push_back(1'b1);
    applyStimulus(1, 1'b1, 1'b1, 1'b1);
    pkt.delete(); pkt.push_back(1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    pkt.delete(); pkt.push_back(1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an LS packet
    mon_off = 1'b1;
    ls_mode[0] = 1'b1;
    ll_bit[0] = 1'b0;
    ll_last[0] = 1'b0;
    ll_start[0] = 1'b1;
    @(posedge clk); #1;
    ll_start[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("pre_reset_en", 0, {en[0], busy[0]}, 2'b11);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_reset", 0, {en[0], busy[0], ll_ack[0], dp[0], dn[0]}, 5'b00010);
    @(posedge clk); #1;
    rst = 1'b0;
    ls_mode[0] = 1'b0;
    @(posedge clk); #1;
    mon_off = 1'b0;

    for (int k = 0; k < 24; k++) begin
      s = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) pkt.delete();
      else setSync();
      len = $urandom_range(1, 20);
      repeat (len) pkt.push_back($urandom_range(0, 3) != 0);
      applyStimulus(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
